// File: rtl/cordic_mul_pkg.sv
// Shared types and constants for the CORDIC shift-and-add multiplier.
// Contents: FSM state enum, datapath widths, iteration count, approximate-bit count.
package cordic_mul_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned PROD_W      = 16;
    localparam int unsigned RES_W       = DATA_W + 1;
    localparam int unsigned ITER        = 8;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned APPROX_BITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/approx_adder_16.sv
// Combinational 16-bit accumulator adder.
// Build option: APPROX_ADD_EN defined -> low APPROX_BITS are OR-combined, and
// only a[2]&b[2] carries into the exact upper add; undefined -> exact adder.
// Ports: a_i, b_i (addends), sum_o (sum, wraps modulo 2^16).
module approx_adder_16
    import cordic_mul_pkg::*;
(
    input  logic [PROD_W-1:0] a_i,
    input  logic [PROD_W-1:0] b_i,
    output logic [PROD_W-1:0] sum_o
);

`ifdef APPROX_ADD_EN
    localparam int unsigned HI_W = PROD_W - APPROX_BITS;

    logic carry_c;

    // The top approximate bit stands in for the whole low-part carry.
    assign carry_c = a_i[APPROX_BITS-1] & b_i[APPROX_BITS-1];
    assign sum_o[APPROX_BITS-1:0] = a_i[APPROX_BITS-1:0] | b_i[APPROX_BITS-1:0];
    assign sum_o[PROD_W-1:APPROX_BITS] = a_i[PROD_W-1:APPROX_BITS]
                                       + b_i[PROD_W-1:APPROX_BITS]
                                       + HI_W'(carry_c);
`else
    assign sum_o = a_i + b_i;
`endif

endmodule

// File: rtl/cordic_multiplier_approx_3bd.sv
// Sequential 8x8 signed multiplier using linear-mode CORDIC iterations.
// One iteration per cycle for i = 7..0; result valid 8 cycles after start.
// Build option: APPROX_ADD_EN selects the approximate accumulator adder.
// Ports: clk, rst_n (sync, active-low), start, x, z (signed operands),
//        y (16-bit product, valid while done), done.
module cordic_multiplier_approx_3bd
    import cordic_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] z,
    output logic [PROD_W-1:0] y,
    output logic              done
);

    state_e             state_q;
    logic [PROD_W-1:0]  xr_q;
    logic [PROD_W-1:0]  y_q;
    logic [RES_W-1:0]   r_q;
    logic [CNT_W-1:0]   i_q;
    logic               done_q;

    logic [PROD_W-1:0]  shifted_c;
    logic [PROD_W-1:0]  addend_c;
    logic [PROD_W-1:0]  sum_c;
    logic [RES_W-1:0]   step_c;
    logic [RES_W-1:0]   r_next_c;
    logic               r_zero_c;
    logic               r_neg_c;

    // Direction d = sign(r); the addend is +/-(xr<<i) or zero.
    always_comb begin
        r_zero_c  = (r_q == '0);
        r_neg_c   = r_q[RES_W-1];
        shifted_c = xr_q << i_q;
        step_c    = RES_W'(1) << i_q;
        addend_c  = '0;
        r_next_c  = r_q;
        if (!r_zero_c) begin
            if (r_neg_c) begin
                addend_c = PROD_W'(0) - shifted_c;
                r_next_c = r_q + step_c;
            end else begin
                addend_c = shifted_c;
                r_next_c = r_q - step_c;
            end
        end
    end

    approx_adder_16 u_acc_add (
        .a_i   (y_q),
        .b_i   (addend_c),
        .sum_o (sum_c)
    );

    // FSM, iteration counter, residual and accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xr_q    <= '0;
            y_q     <= '0;
            r_q     <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        xr_q    <= {{(PROD_W-DATA_W){x[DATA_W-1]}}, x};
                        r_q     <= {z[DATA_W-1], z};
                        y_q     <= '0;
                        i_q     <= CNT_W'(ITER - 1);
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    y_q <= sum_c;
                    r_q <= r_next_c;
                    i_q <= i_q - CNT_W'(1);
                    if (i_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_q;
    assign done = done_q;

endmodule

// File: tb/tb_cordic_multiplier_approx_3bd.sv
// Self-checking bench for cordic_multiplier_approx_3bd.
// Expected products are pushed to a scoreboard queue at start and popped when done rises.
// Build option: APPROX_ADD_EN switches result checks from exact to |error| <= 24.
module tb_cordic_multiplier_approx_3bd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  z;
    logic [15:0] y;
    logic        done;

    int errors;
    int checks;
    int exp_q[$];

    cordic_multiplier_approx_3bd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .z     (z),
        .y     (y),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int y_signed();
        logic signed [15:0] ys;
        ys = y;
        return int'(ys);
    endfunction

    task automatic check_prod(input string tag, input int obs, input int exp);
`ifdef APPROX_ADD_EN
        int diff;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        checks++;
        assert (diff <= 24) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (+/-24)", tag, obs, exp);
        end
`else
        check_eq(tag, obs, exp);
`endif
    endtask

    // Drive one operation; optionally pulse a second start mid-RUN.
    task automatic run_op(input int xv, input int zv, input bit probe);
        int lat;
        int exp;
        int y_hold;
        @(negedge clk);
        start = 1'b1;
        x = 8'(xv);
        z = 8'(zv);
        exp_q.push_back(xv * zv);
        @(posedge clk);
        #1;
        check_eq("done_drop_on_start", int'(done), 0);
        @(negedge clk);
        start = 1'b0;
        lat = 20;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (probe && k == 2) begin
                start = 1'b1;
                x = 8'sd99;
                z = -8'sd99;
            end
            if (probe && k == 3) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check_eq("latency", lat, 8);
        exp = exp_q.pop_front();
        check_prod("product", y_signed(), exp);
        y_hold = y_signed();
        @(posedge clk);
        #1;
        check_eq("done_hold", int'(done), 1);
        check_eq("y_stable", y_signed(), y_hold);
    endtask

    initial begin
        bit spurious;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        start = 1'b0;
        x = '0;
        z = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_y", int'(y), 0);
        check_eq("reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3, 5, 1'b0);
        run_op(127, 127, 1'b0);
        run_op(-128, -128, 1'b0);
        run_op(-128, 127, 1'b0);
        run_op(0, -77, 1'b0);
        run_op(55, 0, 1'b0);
        run_op(-37, 21, 1'b1);
        run_op(100, -3, 1'b0);

        // Abort in the middle of RUN.
        @(negedge clk);
        start = 1'b1;
        x = 8'sd50;
        z = 8'sd60;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midreset_done", int'(done), 0);
        check_eq("midreset_y", int'(y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) spurious = 1'b1;
        end
        check_eq("no_spurious_done", int'(spurious), 0);

        run_op(-1, -1, 1'b0);

        // Strided sweep over the operand space, corners included.
        for (int xv = -128; xv <= 127; xv += 17) begin
            for (int zv = -128; zv <= 127; zv += 13) run_op(xv, zv, 1'b0);
            run_op(xv, 127, 1'b0);
        end
        for (int n = 0; n < 60; n++)
            run_op(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1'b0);

        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
